// File: rtl/conv_window_sched.sv
// Window sequencer for the single-MAC valid 2-D convolution datapath.
// It walks an MxM kernel over an NxN image. For each output pixel it issues the tap
// addresses and MAC strobes, waits out the accumulator latency, then offers the pixel
// coordinate on a valid/ready handshake.
module conv_window_sched #(
  parameter int unsigned N   = 16,
  parameter int unsigned M   = 5,
  parameter int unsigned LAT = 2,
  parameter int unsigned IAW = (N * N > 1) ? $clog2(N * N) : 1,
  parameter int unsigned WAW = (M * M > 1) ? $clog2(M * M) : 1,
  parameter int unsigned CW  = (N - M + 1 > 1) ? $clog2(N - M + 1) : 1
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic           abort,
  output logic           busy,
  output logic           done,
  output logic [IAW-1:0] img_addr,
  output logic [WAW-1:0] w_addr,
  output logic           mac_en,
  output logic           mac_first,
  output logic           mac_last,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [CW-1:0]  out_row,
  output logic [CW-1:0]  out_col
);

  // Kernel tap counter width (holds M-1) and latency counter width (holds LAT-1).
  localparam int unsigned PW    = (M > 1) ? $clog2(M) : 1;
  localparam int unsigned LW    = (LAT > 1) ? $clog2(LAT) : 1;
  localparam int unsigned LatM1 = (LAT > 0) ? LAT - 1 : 0;

  typedef enum logic [2:0] {
    StIdle,
    StMac,
    StWait,
    StEmit,
    StDone
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] k_q, k_d;
  logic [CW-1:0] l_q, l_d;
  logic [PW-1:0] p_q, p_d;
  logic [PW-1:0] q_q, q_d;
  logic [LW-1:0] wait_q, wait_d;

  logic last_tap;
  logic last_win;

  assign last_tap = (p_q == PW'(M - 1)) && (q_q == PW'(M - 1));
  assign last_win = (k_q == CW'(N - M)) && (l_q == CW'(N - M));

  // State and counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      k_q     <= '0;
      l_q     <= '0;
      p_q     <= '0;
      q_q     <= '0;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      l_q     <= l_d;
      p_q     <= p_d;
      q_q     <= q_d;
      wait_q  <= wait_d;
    end
  end

  // Next-state and counter update; abort overrides everything while busy.
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    l_d     = l_q;
    p_d     = p_q;
    q_d     = q_q;
    wait_d  = wait_q;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StMac;
          k_d     = '0;
          l_d     = '0;
          p_d     = '0;
          q_d     = '0;
        end
      end
      StMac: begin
        // p/q stay on the final tap so the addresses hold through WAIT and EMIT.
        if (last_tap) begin
          state_d = (LAT == 0) ? StEmit : StWait;
          wait_d  = '0;
        end else if (q_q == PW'(M - 1)) begin
          q_d = '0;
          p_d = p_q + PW'(1);
        end else begin
          q_d = q_q + PW'(1);
        end
      end
      StWait: begin
        if (wait_q == LW'(LatM1)) begin
          state_d = StEmit;
        end else begin
          wait_d = wait_q + LW'(1);
        end
      end
      StEmit: begin
        if (out_ready) begin
          if (last_win) begin
            state_d = StDone;
          end else begin
            state_d = StMac;
            p_d     = '0;
            q_d     = '0;
            if (l_q == CW'(N - M)) begin
              l_d = '0;
              k_d = k_q + CW'(1);
            end else begin
              l_d = l_q + CW'(1);
            end
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    if (abort && (state_q != StIdle)) begin
      state_d = StIdle;
      k_d     = '0;
      l_d     = '0;
      p_d     = '0;
      q_d     = '0;
      wait_d  = '0;
    end
  end

  // Strobes decode the registered state; addresses follow the live counters.
  always_comb begin
    busy      = (state_q != StIdle);
    mac_en    = (state_q == StMac);
    mac_first = mac_en && (p_q == '0) && (q_q == '0);
    mac_last  = mac_en && last_tap;
    out_valid = (state_q == StEmit);
    done      = (state_q == StDone);
    out_row   = k_q;
    out_col   = l_q;
    img_addr  = (IAW'(k_q) + IAW'(p_q)) * IAW'(N) + IAW'(l_q) + IAW'(q_q);
    w_addr    = WAW'(p_q) * WAW'(M) + WAW'(q_q);
  end

endmodule

// File: tb/tb_conv_window_sched.sv
// Scoreboard bench for conv_window_sched: a small instance (N=4, M=2, LAT=1) driven
// through several scenarios, and a default-sized instance run once end to end.
module tb_conv_window_sched;

  localparam int unsigned SN   = 4;
  localparam int unsigned SM   = 2;
  localparam int unsigned SL   = 1;
  localparam int unsigned SIAW = $clog2(SN * SN);
  localparam int unsigned SWAW = $clog2(SM * SM);
  localparam int unsigned SCW  = $clog2(SN - SM + 1);
  localparam int unsigned SWIN = (SN - SM + 1) * (SN - SM + 1);

  localparam int unsigned BN   = 16;
  localparam int unsigned BM   = 5;
  localparam int unsigned BL   = 2;
  localparam int unsigned BIAW = $clog2(BN * BN);
  localparam int unsigned BWAW = $clog2(BM * BM);
  localparam int unsigned BCW  = $clog2(BN - BM + 1);
  localparam int unsigned BWIN = (BN - BM + 1) * (BN - BM + 1);

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Small instance signals.
  logic            rst_n, start, abort, out_ready;
  logic            busy, done, mac_en, mac_first, mac_last, out_valid;
  logic [SIAW-1:0] img_addr;
  logic [SWAW-1:0] w_addr;
  logic [SCW-1:0]  out_row, out_col;

  // Default-size instance signals.
  logic            b_rst_n, b_start, b_abort, b_out_ready;
  logic            b_busy, b_done, b_mac_en, b_mac_first, b_mac_last, b_out_valid;
  logic [BIAW-1:0] b_img_addr;
  logic [BWAW-1:0] b_w_addr;
  logic [BCW-1:0]  b_out_row, b_out_col;

  conv_window_sched #(.N(SN), .M(SM), .LAT(SL)) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .abort     (abort),
    .busy      (busy),
    .done      (done),
    .img_addr  (img_addr),
    .w_addr    (w_addr),
    .mac_en    (mac_en),
    .mac_first (mac_first),
    .mac_last  (mac_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_row   (out_row),
    .out_col   (out_col)
  );

  conv_window_sched u_big (
    .clk       (clk),
    .rst_n     (b_rst_n),
    .start     (b_start),
    .abort     (b_abort),
    .busy      (b_busy),
    .done      (b_done),
    .img_addr  (b_img_addr),
    .w_addr    (b_w_addr),
    .mac_en    (b_mac_en),
    .mac_first (b_mac_first),
    .mac_last  (b_mac_last),
    .out_valid (b_out_valid),
    .out_ready (b_out_ready),
    .out_row   (b_out_row),
    .out_col   (b_out_col)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input int unsigned act, input int unsigned exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail(input string name, input string why);
    n_cmp++;
    n_err++;
    $display("FAIL %s: %s (t=%0t)", name, why, $time);
  endtask

  // Reference model: the tap stream and pixel order for one full image.
  typedef struct {
    int unsigned img;
    int unsigned w;
    bit          first;
    bit          last;
  } tap_t;

  typedef struct {
    int unsigned row;
    int unsigned col;
  } pix_t;

  tap_t tap_q[$];
  pix_t pix_q[$];

  function automatic void push_image();
    for (int k = 0; k <= int'(SN - SM); k++) begin
      for (int l = 0; l <= int'(SN - SM); l++) begin
        for (int p = 0; p < int'(SM); p++) begin
          for (int q = 0; q < int'(SM); q++) begin
            tap_t t;
            t.img   = (k + p) * SN + (l + q);
            t.w     = p * SM + q;
            t.first = (p == 0) && (q == 0);
            t.last  = (p == int'(SM) - 1) && (q == int'(SM) - 1);
            tap_q.push_back(t);
          end
        end
        pix_q.push_back('{row: k, col: l});
      end
    end
  endfunction

  // Monitor state.
  bit prev_valid;
  int since_last;
  bit expect_mac;
  bit done_pending;

  task automatic flush();
    tap_q.delete();
    pix_q.delete();
    prev_valid   = 1'b0;
    since_last   = 0;
    expect_mac   = 1'b0;
    done_pending = 1'b0;
  endtask

  // Monitor: compares every MAC tap and every offered pixel against the queues.
  always @(negedge clk) begin
    if (rst_n) begin
      if (done_pending) begin
        check("done_pulse", done, 1);
        done_pending = 1'b0;
      end else if (done) begin
        fail("done_spurious", "done high without a final handshake");
      end
      if (expect_mac) begin
        check("restart_after_hs", mac_en, 1);
        expect_mac = 1'b0;
      end
      if (mac_en) begin
        if (tap_q.size() == 0) begin
          fail("tap_extra", "mac_en with no tap expected");
        end else begin
          tap_t t;
          t = tap_q.pop_front();
          check("img_addr", img_addr, t.img);
          check("w_addr", w_addr, t.w);
          check("mac_first", mac_first, t.first);
          check("mac_last", mac_last, t.last);
        end
      end
      if (mac_en && mac_last) since_last = 0;
      else if (since_last < 1000) since_last++;
      if (out_valid) begin
        check("no_mac_in_emit", mac_en, 0);
        if (!prev_valid) check("lat_gap", since_last, SL + 1);
        if (pix_q.size() == 0) begin
          fail("pix_extra", "out_valid with no pixel expected");
        end else begin
          check("out_row", out_row, pix_q[0].row);
          check("out_col", out_col, pix_q[0].col);
          if (out_ready && !abort) begin
            void'(pix_q.pop_front());
            if (pix_q.size() == 0) done_pending = 1'b1;
            else expect_mac = 1'b1;
          end
        end
      end
      prev_valid = out_valid && !(out_ready && !abort);
    end
  end

  // mode 0: ready high; 1: 5-cycle stall on (0,1) plus a start pulse while busy; 2: random.
  task automatic run_image(input int mode, input bit do_abort);
    int cycles;
    int stalls;
    int taps;
    int stall_left;
    cycles     = 0;
    stalls     = 0;
    taps       = 0;
    stall_left = 5;
    push_image();
    start     = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    start  = 1'b0;
    cycles = 1;
    check("busy_after_start", busy, 1);
    while (!done && cycles < 2000) begin
      if (mac_en) taps++;
      if (do_abort && mac_en && taps == 19) begin
        // 19th tap is the 3rd tap of window (1,1).
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_mac_en", mac_en, 0);
        flush();
        repeat (4) @(posedge clk);
        #1;
        check("abort_stays_idle", busy, 0);
        return;
      end
      start = (mode == 1) && mac_en && (taps == 10);
      case (mode)
        1: begin
          if (out_valid && out_row == 0 && out_col == 1 && stall_left > 0) begin
            out_ready = 1'b0;
            stall_left--;
          end else begin
            out_ready = 1'b1;
          end
        end
        2:       out_ready = ($urandom_range(0, 2) != 0);
        default: out_ready = 1'b1;
      endcase
      if (out_valid && !out_ready) stalls++;
      @(posedge clk);
      #1;
      cycles++;
    end
    start = 1'b0;
    if (!done) begin
      fail("done_timeout", "no done within 2000 cycles");
    end else begin
      check("image_cycles", cycles, SWIN * (SM * SM + SL + 1) + 1 + stalls);
      if (mode == 1) check("stall_count", stalls, 5);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("idle_after_done", busy, 0);
    check("queue_drained", tap_q.size() + pix_q.size(), 0);
  endtask

  task automatic reset_mid_wait();
    int n;
    n = 0;
    push_image();
    start     = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    // Second window's WAIT cycle: busy with no strobe active.
    while (!(busy && !mac_en && !out_valid && !done && tap_q.size() < SWIN * SM * SM - SM * SM)
           && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 200) fail("wait_timeout", "WAIT state not reached");
    rst_n = 1'b0;
    #1;
    check("rst_busy", busy, 0);
    check("rst_mac_en", mac_en, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_done", done, 0);
    check("rst_img_addr", img_addr, 0);
    check("rst_w_addr", w_addr, 0);
    check("rst_row_col", {out_row, out_col}, 0);
    flush();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Default-size instance: one full image with ready tied high.
  bit          big_fin;
  int          b_windows, b_taps, b_dones;
  int unsigned b_first_img, b_last_img;

  always @(negedge clk) begin
    if (b_rst_n) begin
      if (b_out_valid && b_out_ready) b_windows++;
      if (b_mac_en) b_taps++;
      if (b_mac_en && b_mac_first) b_first_img = b_img_addr;
      if (b_mac_en && b_mac_last) b_last_img = b_img_addr;
      if (b_done) b_dones++;
    end
  end

  initial begin
    int cyc;
    big_fin     = 1'b0;
    b_windows   = 0;
    b_taps      = 0;
    b_dones     = 0;
    b_first_img = 0;
    b_last_img  = 0;
    b_rst_n     = 1'b0;
    b_start     = 1'b0;
    b_abort     = 1'b0;
    b_out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    b_rst_n = 1'b1;
    @(posedge clk);
    #1;
    b_start = 1'b1;
    @(posedge clk);
    #1;
    b_start = 1'b0;
    cyc     = 1;
    while (!b_done && cyc < 6000) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    if (!b_done) fail("big_timeout", "default instance never finished");
    else check("big_cycles", cyc, BWIN * (BM * BM + BL + 1) + 1);
    repeat (3) @(posedge clk);
    check("big_windows", b_windows, BWIN);
    check("big_taps", b_taps, BWIN * BM * BM);
    check("big_done_count", b_dones, 1);
    check("big_final_first", b_first_img, (BN - BM) * BN + (BN - BM));
    check("big_final_last", b_last_img, BN * BN - 1);
    big_fin = 1'b1;
  end

  initial begin
    rst_n     = 1'b0;
    start     = 1'b0;
    abort     = 1'b0;
    out_ready = 1'b1;
    flush();
    #2;
    check("reset_busy", busy, 0);
    check("reset_mac_en", mac_en, 0);
    check("reset_img_addr", img_addr, 0);
    check("reset_out_valid", out_valid, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    run_image(0, 1'b0);
    run_image(1, 1'b0);
    run_image(2, 1'b0);
    run_image(0, 1'b1);
    run_image(0, 1'b0);
    reset_mid_wait();
    run_image(0, 1'b0);
    run_image(2, 1'b0);

    for (int i = 0; i < 8000 && !big_fin; i++) @(posedge clk);
    if (!big_fin) fail("big_wait", "default instance check did not complete");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/conv_window_sched.md
Name: conv_window_sched

Overview:
- Sequencer for the single-MAC 2-D valid convolution datapath. It slides an MxM kernel over an NxN image held in the image and weight memories.
- Per output pixel it generates image and weight read addresses and MAC enable/first/last strobes, waits out the datapath latency, then presents the pixel coordinate on a valid/ready output handshake.
- Sits between the top-level start/done control and the MAC/memory datapath, replacing in-datapath loop counters.

Parameters:
- N, 16, image side length (pixels).
- M, 5, kernel side length; N >= M >= 1.
- LAT, 2, cycles from the last mac_en to the accumulator result being stable; LAT >= 0.
- IAW, $clog2(N*N), image address width.
- WAW, $clog2(M*M), weight address width (minimum 1).
- CW, $clog2(N-M+1), output row/col width (minimum 1).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  begin one full-image convolution; sampled only in IDLE.
- abort  in  1  synchronous cancel; highest priority after reset.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse after the last output pixel is accepted.
- img_addr  out  IAW  image read address (k+p)*N+(l+q).
- w_addr  out  WAW  weight read address p*M+q.
- mac_en  out  1  accumulate this cycle's addressed operands.
- mac_first  out  1  with mac_en: accumulator loads the product instead of adding (tap p=0,q=0).
- mac_last  out  1  with mac_en: final tap (p=M-1,q=M-1).
- out_valid  out  1  accumulator holds the completed pixel (out_row,out_col).
- out_ready  in  1  downstream accepts the pixel.
- out_row  out  CW  output row k.
- out_col  out  CW  output col l.

Behaviour:
- Reset (rst_n low, async): state=IDLE; k,l,p,q=0; every output 0.
- States and transitions:
  - IDLE: start -> MAC with k=l=p=q=0. start while busy is ignored.
  - MAC: one tap per cycle. mac_en=1; addresses are combinational from the current k,l,p,q. q increments; at q=M-1, q->0 and p++. The tap with p=M-1,q=M-1 goes to WAIT, or directly to EMIT if LAT=0.
  - WAIT: counts LAT cycles with mac_en=0, then goes to EMIT.
  - EMIT: out_valid=1; out_row/out_col held stable until out_valid&out_ready.
    - On handshake, if k=N-M and l=N-M: go to DONE.
    - Otherwise l++; at l=N-M, l->0 and k++. p,q clear and the state returns to MAC.
  - DONE: done=1 for exactly one cycle, then IDLE.
- Outputs mac_en, mac_first, mac_last, out_valid and done are registered state decodes. They are 0 outside their states. Addresses hold their last value when mac_en=0.
- Throughput: a window takes M*M + LAT + 1 cycles with out_ready tied high. Each cycle out_ready is low in EMIT adds one cycle.
- Full image: (N-M+1)^2 windows, in row-major order (k outer, l inner). There are exactly M*M mac_en cycles per window.
- Boundaries:
  - M=N gives a single window at (0,0).
  - M=1 gives mac_first=mac_last=1 on the same cycle.
  - Max img_addr is N*N-1 and max w_addr is M*M-1. No wrap beyond these.
- abort in any busy state: the next state is IDLE, counters clear, all strobes drop, no done pulse. abort in IDLE has no effect. abort and out_ready in the same cycle: abort wins, the pixel is not counted.
- rst_n asserted mid-operation: immediate return to the reset state. start after reset release restarts from window (0,0).
- start in the DONE cycle is ignored. start on the first IDLE cycle is accepted.

Test Plan:
- N=4,M=2,LAT=1, out_ready=1, pulse start:
  - window (0,0): img_addr 0,1,4,5 and w_addr 0,1,2,3 on consecutive mac_en cycles.
  - mac_first on the first of those cycles, mac_last on the fourth.
  - out_valid 2 cycles after mac_last.
  - 9 windows, 6 cycles each; done pulses once.
- Same config: window (1,2) issues img_addr 6,7,10,11. Windows are output in order (0,0),(0,1),(0,2),(1,0)..(2,2).
- out_ready low for 5 cycles in window (0,1): out_valid, out_row=0, out_col=1 held stable. No mac_en during the stall. The next window starts the cycle after the handshake.
- abort on the 3rd MAC cycle of window (1,1): busy drops next cycle, no done. A following start begins at img_addr 0.
- rst_n pulsed low mid-WAIT: all outputs 0 immediately and state IDLE. start while busy (during MAC) has no effect on the counters.
- Defaults N=16,M=5,LAT=2, out_ready=1: 144 out_valid pulses; done at 144*28 cycles after start acceptance, ±1 for the DONE state. Final window issues img_addr 187 then 255 as its first and last taps.
